branch_predictor_unit: RTL

BRANCH_PREDICTOR_UNIT -- requirements
Module: branch_predictor_unit

---
 rtl/branch_predictor_unit.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/branch_predictor_unit.sv
// -----------------------------------------------------------------------------
// branch_predictor_unit
//
// Purpose:
//   Direct-mapped branch target buffer with one saturating direction counter
//   per entry. The fetch side reads the table combinationally and produces a
//   predicted direction and next PC. The resolve side trains the table and
//   raises a registered one-cycle misprediction pulse together with the PC
//   that fetch must be redirected to.
//
// Optional feature:
//   BRANCH_PREDICTOR_STATS_EN - when defined, builds two saturating statistics
//   counters (resolved branches, mispredictions). When undefined, no
//   statistics registers exist and both statistics outputs are tied to zero.
//
// Ports:
//   i_clock              clock; all state changes on the rising edge
//   i_reset              asynchronous active-high reset
//   i_enable_etapa       stage enable; 0 freezes the table and statistics
//   i_flush_btb          synchronous invalidate of every entry
//   i_fetch_pc           PC being fetched this cycle
//   o_prediccion_taken   predicted taken for i_fetch_pc (combinational)
//   o_prediccion_dir     predicted next PC for i_fetch_pc (combinational)
//   i_update_valid       a branch resolved this cycle
//   i_update_pc          PC of the resolved branch
//   i_update_target      resolved branch target
//   i_update_taken       resolved direction
//   i_update_pred_taken  direction predicted at fetch for that branch
//   i_update_pred_dir    next PC predicted at fetch for that branch
//   o_mispredict         registered one-cycle misprediction pulse
//   o_flush_dir          registered correct PC for the fetch redirect
//   o_cant_branches      resolved-branch count (0 without stats)
//   o_cant_mispredict    misprediction count (0 without stats)
// -----------------------------------------------------------------------------
module branch_predictor_unit #(
  parameter int CANT_BITS_ADDR     = 11,
  parameter int CANT_ENTRADAS_BTB  = 16,
  parameter int CANT_BITS_CONTADOR = 2,
  parameter int CANT_BITS_REGISTROS = 32
) (
  input  logic                           i_clock,
  input  logic                           i_reset,
  input  logic                           i_enable_etapa,
  input  logic                           i_flush_btb,
  input  logic [CANT_BITS_ADDR-1:0]      i_fetch_pc,
  output logic                           o_prediccion_taken,
  output logic [CANT_BITS_ADDR-1:0]      o_prediccion_dir,
  input  logic                           i_update_valid,
  input  logic [CANT_BITS_ADDR-1:0]      i_update_pc,
  input  logic [CANT_BITS_ADDR-1:0]      i_update_target,
  input  logic                           i_update_taken,
  input  logic                           i_update_pred_taken,
  input  logic [CANT_BITS_ADDR-1:0]      i_update_pred_dir,
  output logic                           o_mispredict,
  output logic [CANT_BITS_ADDR-1:0]      o_flush_dir,
  output logic [CANT_BITS_REGISTROS-1:0] o_cant_branches,
  output logic [CANT_BITS_REGISTROS-1:0] o_cant_mispredict
);

  localparam int IDX   = $clog2(CANT_ENTRADAS_BTB);
  localparam int TAG_W = CANT_BITS_ADDR - IDX;
  localparam int CW    = CANT_BITS_CONTADOR;

  localparam logic [CW-1:0] CNT_MAX  = '1;
  localparam logic [CW-1:0] CNT_MIN  = '0;
  // Freshly allocated entries start weakly taken: only the MSB set.
  localparam logic [CW-1:0] CNT_WEAK = CW'(1) << (CW - 1);

  // ---------------------------------------------------------------------------
  // Table storage. Each entry lives in its own generate block (so reset can
  // clear every field asynchronously); the flattened views below are what the
  // shared read ports use.
  // ---------------------------------------------------------------------------
  logic [CANT_ENTRADAS_BTB-1:0] valid_vec;
  logic [TAG_W-1:0]             tag_arr    [CANT_ENTRADAS_BTB];
  logic [CANT_BITS_ADDR-1:0]    target_arr [CANT_ENTRADAS_BTB];
  logic [CW-1:0]                cnt_arr    [CANT_ENTRADAS_BTB];

  // ---------------------------------------------------------------------------
  // Fetch-side lookup (combinational, reads pre-update contents).
  // ---------------------------------------------------------------------------
  logic [IDX-1:0]            fetch_idx;
  logic [TAG_W-1:0]          fetch_tag;
  logic                      fetch_hit;
  logic                      fetch_taken;
  logic [CANT_BITS_ADDR-1:0] fetch_seq;

  assign fetch_idx   = i_fetch_pc[IDX-1:0];
  assign fetch_tag   = i_fetch_pc[CANT_BITS_ADDR-1:IDX];
  assign fetch_hit   = valid_vec[fetch_idx] && (tag_arr[fetch_idx] == fetch_tag);
  assign fetch_taken = fetch_hit && cnt_arr[fetch_idx][CW-1];
  assign fetch_seq   = i_fetch_pc + CANT_BITS_ADDR'(1);

  assign o_prediccion_taken = fetch_taken;
  assign o_prediccion_dir   = fetch_taken ? target_arr[fetch_idx] : fetch_seq;

  // ---------------------------------------------------------------------------
  // Resolve-side lookup and counter arithmetic.
  // ---------------------------------------------------------------------------
  logic [IDX-1:0]   upd_idx;
  logic [TAG_W-1:0] upd_tag;
  logic             upd_hit;
  logic [CW-1:0]    upd_cnt;
  logic [CW-1:0]    upd_cnt_next;
  logic             table_write;

  assign upd_idx = i_update_pc[IDX-1:0];
  assign upd_tag = i_update_pc[CANT_BITS_ADDR-1:IDX];
  assign upd_hit = valid_vec[upd_idx] && (tag_arr[upd_idx] == upd_tag);
  assign upd_cnt = cnt_arr[upd_idx];

  // Flush wins over a simultaneous update; the disabled stage writes nothing.
  assign table_write = i_enable_etapa && !i_flush_btb && i_update_valid;

  always_comb begin
    upd_cnt_next = upd_cnt;
    if (i_update_taken) begin
      if (upd_cnt != CNT_MAX) upd_cnt_next = upd_cnt + CW'(1);
    end else begin
      if (upd_cnt != CNT_MIN) upd_cnt_next = upd_cnt - CW'(1);
    end
  end

  generate
    for (genvar gi = 0; gi < CANT_ENTRADAS_BTB; gi++) begin : g_entry
      localparam logic [IDX-1:0] ENTRY_IDX = IDX'(gi);

      logic                      valid_reg;
      logic [TAG_W-1:0]          tag_reg;
      logic [CANT_BITS_ADDR-1:0] target_reg;
      logic [CW-1:0]             cnt_reg;
      logic                      sel;

      assign sel = table_write && (upd_idx == ENTRY_IDX);

      always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
          valid_reg  <= 1'b0;
          tag_reg    <= '0;
          target_reg <= '0;
          cnt_reg    <= '0;
        end else if (i_enable_etapa && i_flush_btb) begin
          valid_reg <= 1'b0;
        end else if (sel) begin
          if (upd_hit) begin
            cnt_reg <= upd_cnt_next;
            if (i_update_taken) target_reg <= i_update_target;
          end else if (i_update_taken) begin
            // Miss on a taken branch: claim the slot, evicting any alias.
            valid_reg  <= 1'b1;
            tag_reg    <= upd_tag;
            target_reg <= i_update_target;
            cnt_reg    <= CNT_WEAK;
          end
          // Miss on a not-taken branch leaves the entry untouched.
        end
      end

      assign valid_vec[gi]  = valid_reg;
      assign tag_arr[gi]    = tag_reg;
      assign target_arr[gi] = target_reg;
      assign cnt_arr[gi]    = cnt_reg;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Misprediction detection and redirect target.
  // A taken branch is also mispredicted when its predicted target was wrong.
  // ---------------------------------------------------------------------------
  logic                      mis_cond;
  logic [CANT_BITS_ADDR-1:0] correct_dir;

  assign mis_cond = i_update_valid &&
                    ((i_update_pred_taken != i_update_taken) ||
                     (i_update_taken && (i_update_pred_dir != i_update_target)));
  assign correct_dir = i_update_taken ? i_update_target
                                      : i_update_pc + CANT_BITS_ADDR'(1);

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      o_mispredict <= 1'b0;
      o_flush_dir  <= '0;
    end else if (i_enable_etapa) begin
      o_mispredict <= mis_cond;
      // The redirect PC only changes when a branch actually resolves.
      if (i_update_valid) o_flush_dir <= correct_dir;
    end else begin
      o_mispredict <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Statistics. Counted even when a flush suppresses the table update.
  // ---------------------------------------------------------------------------
`ifdef BRANCH_PREDICTOR_STATS_EN
  localparam logic [CANT_BITS_REGISTROS-1:0] STAT_MAX = '1;

  logic [CANT_BITS_REGISTROS-1:0] branches_reg;
  logic [CANT_BITS_REGISTROS-1:0] mispredicts_reg;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      branches_reg    <= '0;
      mispredicts_reg <= '0;
    end else if (i_enable_etapa) begin
      if (i_update_valid && (branches_reg != STAT_MAX))
        branches_reg <= branches_reg + CANT_BITS_REGISTROS'(1);
      if (mis_cond && (mispredicts_reg != STAT_MAX))
        mispredicts_reg <= mispredicts_reg + CANT_BITS_REGISTROS'(1);
    end
  end

  assign o_cant_branches   = branches_reg;
  assign o_cant_mispredict = mispredicts_reg;
`else
  assign o_cant_branches   = '0;
  assign o_cant_mispredict = '0;
`endif

endmodule
